// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: command kinds, FSM states, ALU opcodes
// and flag bit positions of the registered ALU block's F register.
package alu_sequencer_pkg;

   typedef enum logic [1:0] {
      CMD_EXEC8  = 2'd0,
      CMD_EXEC16 = 2'd1,
      CMD_LOADAF = 2'd2,
      CMD_READAF = 2'd3
   } cmd_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PASS_LO = 3'd1,
      ST_PASS_HI = 3'd2,
      ST_WB      = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   localparam logic [7:0] ALU_OP_ADD = 8'h00;
   localparam logic [7:0] ALU_OP_ADC = 8'h01;
   localparam logic [7:0] ALU_OP_SUB = 8'h02;
   localparam logic [7:0] ALU_OP_AND = 8'h03;
   localparam logic [7:0] ALU_OP_OR  = 8'h04;
   localparam logic [7:0] ALU_OP_XOR = 8'h05;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   function automatic logic [15:0] zext_byte(input logic [7:0] b);
      return {8'h00, b};
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/response handshake plus the ALU-side bus of the sequencer.
// slave = sequencer side, master = command issuer together with the ALU block.
interface alu_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_kind;
   logic [7:0]  cmd_op;
   logic [7:0]  cmd_op_hi;
   logic [15:0] cmd_x;
   logic [15:0] cmd_y;
   logic        cmd_wa;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic [3:0]  rsp_flags;

   logic [7:0]  alu_op;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic        alu_enable;
   logic        alu_writeA;
   logic        alu_writeF;
   logic [15:0] alu_a;
   logic [15:0] alu_o;
   logic [7:0]  alu_f;

   modport slave (
      input  cmd_valid, cmd_kind, cmd_op, cmd_op_hi, cmd_x, cmd_y, cmd_wa,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_flags,
      input  rsp_ready,
      output alu_op, alu_x, alu_y, alu_enable, alu_writeA, alu_writeF,
      input  alu_a, alu_o, alu_f
   );

   modport master (
      output cmd_valid, cmd_kind, cmd_op, cmd_op_hi, cmd_x, cmd_y, cmd_wa,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_flags,
      output rsp_ready,
      input  alu_op, alu_x, alu_y, alu_enable, alu_writeA, alu_writeF,
      output alu_a, alu_o, alu_f
   );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences 8/16-bit operations and A/F load/read through a registered ALU block.
// state      | meaning
// IDLE       | cmd_ready high, waiting for a command
// PASS_LO    | first (or only) ALU pass, or A/F load
// PASS_HI    | high-byte pass of EXEC16, carry taken from ALU F
// WB         | build response payload from result or ALU A/F
// RESP       | rsp_valid high, payload held until rsp_ready
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   alu_sequencer_if.slave bus
);

   state_e      r_state;
   cmd_kind_e   r_kind;
   logic        r_wa;
   logic [7:0]  r_op_hi;
   logic [7:0]  r_x_hi;
   logic [7:0]  r_y_hi;
   logic [15:0] r_result;

   logic        r_cmd_ready;
   logic        r_rsp_valid;
   logic [15:0] r_rsp_data;
   logic [3:0]  r_rsp_flags;

   logic [7:0]  r_alu_op;
   logic [15:0] r_alu_x;
   logic [15:0] r_alu_y;
   logic        r_alu_enable;
   logic        r_alu_writeA;
   logic        r_alu_writeF;

   cmd_kind_e   w_cmd_kind;
   logic        w_accept;
   logic        w_unused_a_hi;

   assign w_cmd_kind    = cmd_kind_e'(bus.cmd_kind);
   assign w_accept      = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;
   assign w_unused_a_hi = ^bus.alu_a[15:8];

   // ALU controls are registered so they are exactly valid for the PASS_* cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_kind       <= CMD_EXEC8;
         r_wa         <= 1'b0;
         r_op_hi      <= 8'h00;
         r_x_hi       <= 8'h00;
         r_y_hi       <= 8'h00;
         r_result     <= 16'h0000;
         r_cmd_ready  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= 16'h0000;
         r_rsp_flags  <= 4'h0;
         r_alu_op     <= 8'h00;
         r_alu_x      <= 16'h0000;
         r_alu_y      <= 16'h0000;
         r_alu_enable <= 1'b0;
         r_alu_writeA <= 1'b0;
         r_alu_writeF <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  r_kind      <= w_cmd_kind;
                  r_wa        <= bus.cmd_wa;
                  r_op_hi     <= bus.cmd_op_hi;
                  r_x_hi      <= bus.cmd_x[15:8];
                  r_y_hi      <= bus.cmd_y[15:8];
                  r_result    <= bus.cmd_x;
                  case (w_cmd_kind)
                     CMD_EXEC8: begin
                        r_alu_op     <= bus.cmd_op;
                        r_alu_x      <= bus.cmd_x;
                        r_alu_y      <= bus.cmd_y;
                        r_alu_enable <= 1'b1;
                        r_alu_writeA <= bus.cmd_wa;
                        r_state      <= ST_PASS_LO;
                     end
                     CMD_EXEC16: begin
                        r_alu_op     <= bus.cmd_op;
                        r_alu_x      <= zext_byte(bus.cmd_x[7:0]);
                        r_alu_y      <= zext_byte(bus.cmd_y[7:0]);
                        r_alu_enable <= 1'b1;
                        r_alu_writeA <= bus.cmd_wa;
                        r_state      <= ST_PASS_LO;
                     end
                     CMD_LOADAF: begin
                        r_alu_x      <= bus.cmd_x;
                        r_alu_writeA <= 1'b1;
                        r_alu_writeF <= 1'b1;
                        r_state      <= ST_PASS_LO;
                     end
                     default: r_state <= ST_WB;
                  endcase
               end
            end

            ST_PASS_LO: begin
               r_alu_op     <= 8'h00;
               r_alu_x      <= 16'h0000;
               r_alu_y      <= 16'h0000;
               r_alu_enable <= 1'b0;
               r_alu_writeA <= 1'b0;
               r_alu_writeF <= 1'b0;
               r_state      <= ST_WB;
               if (r_kind == CMD_EXEC8) begin
                  r_result <= bus.alu_o;
               end else if (r_kind == CMD_EXEC16) begin
                  r_result[7:0] <= bus.alu_o[7:0];
                  r_alu_op      <= r_op_hi;
                  r_alu_x       <= zext_byte(r_x_hi);
                  r_alu_y       <= zext_byte(r_y_hi);
                  r_alu_enable  <= 1'b1;
                  r_alu_writeA  <= r_wa;
                  r_state       <= ST_PASS_HI;
               end
            end

            ST_PASS_HI: begin
               r_result[15:8] <= bus.alu_o[7:0];
               r_alu_op       <= 8'h00;
               r_alu_x        <= 16'h0000;
               r_alu_y        <= 16'h0000;
               r_alu_enable   <= 1'b0;
               r_alu_writeA   <= 1'b0;
               r_alu_writeF   <= 1'b0;
               r_state        <= ST_WB;
            end

            ST_WB: begin
               r_rsp_flags <= bus.alu_f[3:0];
               r_rsp_data  <= (r_kind == CMD_READAF) ? {bus.alu_a[7:0], bus.alu_f} : r_result;
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end

            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_flags  = r_rsp_flags;
   assign bus.alu_op     = r_alu_op;
   assign bus.alu_x      = r_alu_x;
   assign bus.alu_y      = r_alu_y;
   assign bus.alu_enable = r_alu_enable;
   assign bus.alu_writeA = r_alu_writeA;
   assign bus.alu_writeF = r_alu_writeF;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer paired with a small registered ALU block:
// O is combinational, A/F update on the clock edge of an enabled or load pass.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_sequencer_if u_if ();

   alu_sequencer dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (u_if)
   );

   // registered ALU block: byte-oriented flags, carry-in from F for ADC
   logic [15:0] alu_a_q;
   logic [7:0]  alu_f_q;
   logic [15:0] w_o;
   logic [8:0]  w_byte;
   logic [7:0]  w_f;

   always_comb begin
      w_o    = u_if.alu_x;
      w_byte = 9'h000;
      case (u_if.alu_op)
         ALU_OP_ADD: begin
            w_o    = u_if.alu_x + u_if.alu_y;
            w_byte = {1'b0, u_if.alu_x[7:0]} + {1'b0, u_if.alu_y[7:0]};
         end
         ALU_OP_ADC: begin
            w_o    = u_if.alu_x + u_if.alu_y + {15'h0000, alu_f_q[FLAG_C]};
            w_byte = {1'b0, u_if.alu_x[7:0]} + {1'b0, u_if.alu_y[7:0]} + {8'h00, alu_f_q[FLAG_C]};
         end
         ALU_OP_SUB: begin
            w_o    = u_if.alu_x - u_if.alu_y;
            w_byte = {1'b0, u_if.alu_x[7:0]} - {1'b0, u_if.alu_y[7:0]};
         end
         ALU_OP_AND: w_o = u_if.alu_x & u_if.alu_y;
         ALU_OP_OR:  w_o = u_if.alu_x | u_if.alu_y;
         ALU_OP_XOR: w_o = u_if.alu_x ^ u_if.alu_y;
         default:    w_o = u_if.alu_x;
      endcase
      w_f         = 8'h00;
      w_f[FLAG_C] = w_byte[8];
      w_f[FLAG_Z] = (w_o[7:0] == 8'h00);
      w_f[FLAG_N] = w_o[7];
      w_f[FLAG_V] = 1'b0;
   end

   assign u_if.alu_o = w_o;
   assign u_if.alu_a = alu_a_q;
   assign u_if.alu_f = alu_f_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_q <= 16'h0000;
         alu_f_q <= 8'h00;
      end else if (u_if.alu_enable) begin
         alu_f_q <= w_f;
         if (u_if.alu_writeA) alu_a_q <= w_o;
      end else begin
         if (u_if.alu_writeA) alu_a_q <= u_if.alu_x;
         if (u_if.alu_writeF) alu_f_q <= u_if.alu_x[15:8];
      end
   end

   typedef struct {
      logic [1:0]  kind;
      logic [7:0]  op;
      logic [7:0]  op_hi;
      logic [15:0] x;
      logic [15:0] y;
      logic        wa;
      logic [15:0] exp_data;
      logic [3:0]  exp_flags;
      int          exp_lat;
      logic [15:0] exp_a;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;
   vec_t vecs[14];

   function automatic vec_t mk(input logic [1:0] kind, input logic [7:0] op, input logic [7:0] op_hi,
                               input logic [15:0] x, input logic [15:0] y, input logic wa,
                               input logic [15:0] d, input logic [3:0] f, input int lat,
                               input logic [15:0] a);
      vec_t v;
      v.kind = kind; v.op = op; v.op_hi = op_hi; v.x = x; v.y = y; v.wa = wa;
      v.exp_data = d; v.exp_flags = f; v.exp_lat = lat; v.exp_a = a;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic issue(input vec_t v, input string tag);
      bit seen;
      @(negedge clk);
      u_if.cmd_kind  = v.kind;
      u_if.cmd_op    = v.op;
      u_if.cmd_op_hi = v.op_hi;
      u_if.cmd_x     = v.x;
      u_if.cmd_y     = v.y;
      u_if.cmd_wa    = v.wa;
      u_if.cmd_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (u_if.cmd_ready) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_accept"}, 32'(seen), 32'd1);
      if (seen) @(posedge clk);
      #1 u_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         lat++;
         if (u_if.rsp_valid) break;
      end
   endtask

   task automatic release_rsp();
      u_if.rsp_ready = 1'b1;
      @(posedge clk);
      #1 u_if.rsp_ready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      issue(v, tag);
      wait_rsp(lat);
      chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
      chk({tag, "_data"}, 32'(u_if.rsp_data), 32'(v.exp_data));
      chk({tag, "_flags"}, 32'(u_if.rsp_flags), 32'(v.exp_flags));
      chk({tag, "_alu_a"}, 32'(alu_a_q), 32'(v.exp_a));
      chk({tag, "_alu_idle"}, 32'(|{u_if.alu_enable, u_if.alu_writeA, u_if.alu_writeF,
                                    u_if.alu_op, u_if.alu_x, u_if.alu_y}), 32'd0);
      chk({tag, "_ready_low"}, 32'(u_if.cmd_ready), 32'd0);
      release_rsp();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat;
      vec_t v;

      vecs[0]  = mk(CMD_EXEC8,  ALU_OP_ADD, 8'h00,      16'h0012, 16'h0034, 1'b1, 16'h0046, 4'h0, 3, 16'h0046);
      vecs[1]  = mk(CMD_EXEC16, ALU_OP_ADD, ALU_OP_ADC, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 4'h0, 4, 16'h0046);
      vecs[2]  = mk(CMD_LOADAF, 8'h00,      8'h00,      16'h0B5A, 16'h0000, 1'b0, 16'h0B5A, 4'hB, 3, 16'h0B5A);
      vecs[3]  = mk(CMD_READAF, 8'h00,      8'h00,      16'h0000, 16'h0000, 1'b0, 16'h5A0B, 4'hB, 2, 16'h0B5A);
      vecs[4]  = mk(CMD_EXEC8,  ALU_OP_SUB, 8'h00,      16'h0010, 16'h0010, 1'b1, 16'h0000, 4'h2, 3, 16'h0000);
      vecs[5]  = mk(CMD_EXEC8,  ALU_OP_AND, 8'h00,      16'h00F0, 16'h003C, 1'b0, 16'h0030, 4'h0, 3, 16'h0000);
      vecs[6]  = mk(CMD_EXEC16, ALU_OP_ADD, ALU_OP_ADC, 16'h00FF, 16'h00FF, 1'b1, 16'h01FE, 4'h0, 4, 16'h0001);
      vecs[7]  = mk(CMD_EXEC16, ALU_OP_XOR, ALU_OP_XOR, 16'hA5A5, 16'hFFFF, 1'b1, 16'h5A5A, 4'h0, 4, 16'h005A);
      vecs[8]  = mk(CMD_READAF, 8'h00,      8'h00,      16'h0000, 16'h0000, 1'b0, 16'h5A00, 4'h0, 2, 16'h005A);
      vecs[9]  = mk(CMD_EXEC8,  ALU_OP_ADD, 8'h00,      16'h1234, 16'h1111, 1'b1, 16'h2345, 4'h0, 3, 16'h2345);
      vecs[10] = mk(CMD_EXEC8,  ALU_OP_ADD, 8'h00,      16'h0080, 16'h0080, 1'b0, 16'h0100, 4'h3, 3, 16'h2345);
      vecs[11] = mk(CMD_LOADAF, 8'h00,      8'h00,      16'h0F80, 16'h1234, 1'b0, 16'h0F80, 4'hF, 3, 16'h0F80);
      vecs[12] = mk(CMD_READAF, 8'h00,      8'h00,      16'h0000, 16'h0000, 1'b1, 16'h800F, 4'hF, 2, 16'h0F80);
      vecs[13] = mk(CMD_EXEC8,  ALU_OP_OR,  8'h00,      16'h00A0, 16'h0005, 1'b1, 16'h00A5, 4'h4, 3, 16'h00A5);

      rst_n          = 1'b0;
      u_if.cmd_valid = 1'b0;
      u_if.cmd_kind  = 2'd0;
      u_if.cmd_op    = 8'h00;
      u_if.cmd_op_hi = 8'h00;
      u_if.cmd_x     = 16'h0000;
      u_if.cmd_y     = 16'h0000;
      u_if.cmd_wa    = 1'b0;
      u_if.rsp_ready = 1'b0;

      #12;
      chk("reset_cmd_ready", 32'(u_if.cmd_ready), 32'd0);
      chk("reset_rsp_valid", 32'(u_if.rsp_valid), 32'd0);
      chk("reset_rsp_data", 32'(u_if.rsp_data), 32'd0);
      chk("reset_rsp_flags", 32'(u_if.rsp_flags), 32'd0);
      chk("reset_alu_outs", 32'(|{u_if.alu_enable, u_if.alu_writeA, u_if.alu_writeF,
                                  u_if.alu_op, u_if.alu_x, u_if.alu_y}), 32'd0);
      #10 rst_n = 1'b1;
      chk("release_ready_before_edge", 32'(u_if.cmd_ready), 32'd0);
      @(negedge clk);
      chk("release_ready_first_edge", 32'(u_if.cmd_ready), 32'd1);

      for (int i = 0; i < 14; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // response stall: payload must hold, extra commands must be dropped
      v = mk(CMD_EXEC8, ALU_OP_ADD, 8'h00, 16'h0001, 16'h0002, 1'b1, 16'h0003, 4'h0, 3, 16'h0003);
      issue(v, "stall");
      wait_rsp(lat);
      chk("stall_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall_hold%0d", i),
             32'({u_if.rsp_valid, u_if.cmd_ready, u_if.alu_enable, u_if.rsp_flags, u_if.rsp_data}),
             32'({1'b1, 1'b0, 1'b0, 4'h0, 16'h0003}));
         u_if.cmd_kind  = CMD_LOADAF;
         u_if.cmd_x     = 16'hFFFF;
         u_if.cmd_valid = i[0];
      end
      u_if.cmd_valid = 1'b0;
      release_rsp();
      run_vec(mk(CMD_READAF, 8'h00, 8'h00, 16'h0000, 16'h0000, 1'b0, 16'h0300, 4'h0, 2, 16'h0003),
              "after_stall");

      // reset during the high pass of an EXEC16
      v = mk(CMD_EXEC16, ALU_OP_ADD, ALU_OP_ADC, 16'h0102, 16'h0304, 1'b1, 16'h0406, 4'h0, 4, 16'h0004);
      issue(v, "rst_mid");
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_in_pass_hi", 32'({u_if.alu_enable, u_if.alu_op, u_if.alu_x}),
          32'({1'b1, ALU_OP_ADC, 16'h0001}));
      rst_n = 1'b0;
      #1;
      chk("rst_mid_alu_enable", 32'(u_if.alu_enable), 32'd0);
      chk("rst_mid_alu_outs", 32'(|{u_if.alu_writeA, u_if.alu_writeF, u_if.alu_op,
                                    u_if.alu_x, u_if.alu_y}), 32'd0);
      chk("rst_mid_rsp", 32'({u_if.rsp_valid, u_if.cmd_ready}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(mk(CMD_EXEC8, ALU_OP_ADD, 8'h00, 16'h0005, 16'h0007, 1'b1, 16'h000C, 4'h0, 3, 16'h000C),
              "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports cmd_valid in 1, cmd_ready out 1: command handshake; transfer when both high at a clk edge.
REQ-004 SHALL have ports cmd_kind in 2 (0 EXEC8, 1 EXEC16, 2 LOADAF, 3 READAF), cmd_op in 8, cmd_op_hi in 8, cmd_x in 16, cmd_y in 16, cmd_wa in 1 (write-A request).
REQ-005 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 16, rsp_flags out 4: response handshake and payload.
REQ-006 SHALL have ALU-side ports alu_op out 8, alu_x out 16, alu_y out 16, alu_enable out 1, alu_writeA out 1, alu_writeF out 1, alu_a in 16, alu_o in 16, alu_f in 8, wired to the registered ALU block's op/X/Y/enable/writeA/writeF/A/O/F.

Function
REQ-007 SHALL implement FSM states IDLE, PASS_LO, PASS_HI, WB, RESP.
REQ-008 SHALL drive cmd_ready high only in IDLE; on transfer latch all cmd_* fields and go to PASS_LO (EXEC8/EXEC16/LOADAF) or WB (READAF).
REQ-009 PASS_LO for EXEC8: alu_op=op, alu_x=x, alu_y=y, alu_enable=1, alu_writeA=wa, alu_writeF=0; capture alu_o into result; next WB.
REQ-010 PASS_LO for EXEC16: alu_x={8'h00,x[7:0]}, alu_y={8'h00,y[7:0]}, alu_op=op, alu_enable=1, alu_writeA=wa; capture alu_o[7:0] as result low byte; next PASS_HI.
REQ-011 PASS_HI: alu_op=op_hi, alu_x={8'h00,x[15:8]}, alu_y={8'h00,y[15:8]}, alu_enable=1, alu_writeA=wa; capture alu_o[7:0] as result high byte; next WB. Carry propagates through the ALU block's F register updated at the PASS_LO edge; sequencer does no carry arithmetic.
REQ-012 PASS_LO for LOADAF: alu_enable=0, alu_writeA=1, alu_writeF=1, alu_x=x; result=x; next WB.
REQ-013 WB: rsp_flags<=alu_f[3:0]; for READAF rsp_data<={alu_a[7:0],alu_f[7:0]}; else rsp_data<=result; next RESP.
REQ-014 RESP: rsp_valid=1; rsp_data/rsp_flags SHALL hold stable until rsp_ready; on handshake go to IDLE.
REQ-015 Outside PASS_LO/PASS_HI alu_enable, alu_writeA, alu_writeF SHALL be 0; alu_op/x/y SHALL be 0.
REQ-016 Latency accept-edge to rsp_valid: EXEC8/LOADAF 3 cycles, EXEC16 4, READAF 2; one command in flight; back-to-back throughput limited only by rsp_ready.
REQ-017 cmd_valid while not IDLE SHALL be ignored (no latch, no side effects).

Reset
REQ-018 reset low SHALL immediately force IDLE, cmd_ready=0 while low, rsp_valid=0, rsp_data=0, rsp_flags=0, all alu_* outputs 0, regardless of state mid-operation.
REQ-019 After reset release, cmd_ready SHALL be high from the first clk edge on.

Structure
REQ-020 cmd_kind encodings, FSM state encodings and ALU op constants SHALL live in the shared CPU package/header.
REQ-021 No sub-module; FSM and result register inline. Bench SHALL pair it with the registered ALU block.

Verification
REQ-022 EXEC8 ADD x=0x0012 y=0x0034 wa=1 -> rsp_data[7:0]=0x46, rsp_flags Z=0 C=0, ALU A=0x0046, rsp_valid 3 cycles after accept.
REQ-023 EXEC16 ADD/ADC x=0x12FF y=0x0001 -> rsp_data=0x1300, low-pass carry consumed by high pass, rsp_valid 4 cycles after accept.
REQ-024 LOADAF x=0x0B5A then READAF -> rsp_data=0x5A0B, rsp_flags=0xB.
REQ-025 rsp_ready held low 5 cycles in RESP -> rsp_data/flags stable, cmd_ready 0, cmd_valid pulses ignored.
REQ-026 reset asserted during PASS_HI -> alu_enable drops same cycle, rsp_valid 0, next command after release completes normally.
